rst_pulse_rx: RTL and testbench
===============================

# rst_pulse_rx

- Consumer end of the reset-pulse interface: receives the `rst_pulse` produced by the edge-triggered reset pulse generator.
- Qualifies the pulse width, holds all downstream Kyber sub-block resets while the pulse is high, then releases them one by one at a fixed spacing.
- Reports completion with a one-cycle `rst_done` pulse.
- Sits between the reset pulse generator and the per-domain reset inputs of the NTT, sampler, and polynomial-arithmetic cores.

## Interface
- `PULSE_MIN`, 10: number of consecutive high samples required to accept a pulse (filter builds only); ≥1.
- `N_STAGES`, 4: number of downstream reset domains; ≥1.
- `STAGE_GAP`, 8: clock cycles between successive stage releases; ≥1.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `rst_pulse`  in  1  reset request from the pulse generator, synchronous to `clk`.
- `stage_rst_n`  out  N_STAGES  active-low per-domain resets; bit 0 is released first.
- `busy`  out  1  high in every state except IDLE.
- `rst_done`  out  1  one-cycle pulse when the last stage is released.
- `glitch_err`  out  1  sticky flag: a pulse was rejected as too short; cleared only by `rst`.

## Operation
- `rst_pulse` is registered once into `p_q`. All decisions use `p_q`.
- Reset values (`rst`=0): state IDLE, `stage_rst_n`=all 1, `busy`=0, `rst_done`=0, `glitch_err`=0, all counters 0.
- States:
  - IDLE: `p_q`=1 → CAPTURE with `wcnt`=1 (filter built), or → HOLD (no filter).
  - CAPTURE: `p_q`=1 increments `wcnt`. When `wcnt` reaches `PULSE_MIN` → HOLD.
    - If `p_q`=0 first: set `glitch_err`. Go → IDLE if `stage_rst_n` is all 1, else → RELEASE, restarting from stage 0.
  - HOLD: `stage_rst_n`=all 0. Stay while `p_q`=1. On `p_q`=0 → RELEASE with `gcnt`=0 and `idx`=0.
  - RELEASE: `gcnt` counts 0..STAGE_GAP-1. At STAGE_GAP-1: set `stage_rst_n[idx]`=1, `gcnt`←0, `idx`++. On the release of stage N_STAGES-1 → DONE.
  - DONE: `rst_done`=1 for exactly this cycle, then → IDLE.
- Re-trigger (`p_q`=1 in RELEASE or DONE):
  - All `stage_rst_n` are driven back to 0 on that same edge.
  - Next state is CAPTURE (`wcnt`=1) with the filter built, HOLD without it.
  - `rst_done` is suppressed.
- Stages are always released in ascending index order. A released stage is re-asserted only by a re-trigger.
- A `rst_pulse` stuck high keeps the block in HOLD indefinitely. This is legal, with no timeout.
- Counter widths: `wcnt` $clog2(PULSE_MIN+1) bits, saturating. `gcnt` $clog2(STAGE_GAP) bits (min 1). `idx` $clog2(N_STAGES) bits (min 1).
- `rst` assertion at any point, including mid-release, forces the reset values immediately (asynchronous).

## Timing
- E0 = first edge that samples `rst_pulse`=1.
- `stage_rst_n` goes to all 0 after:
  - edge E0+1 without the filter;
  - edge E0+PULSE_MIN with the filter, provided `rst_pulse` was sampled high at E0..E0+PULSE_MIN-1.
- F0 = first edge that samples `rst_pulse`=0 while in HOLD. RELEASE is entered at F0+1.
- Stage i goes high after edge F0+1+(i+1)·STAGE_GAP.
- `rst_done` is high for the single cycle following the last stage's release edge. `busy` falls one edge later.
- `busy` rises on the edge that leaves IDLE.
- All outputs are registered; no combinational input→output path.

## Configuration
- `RST_PULSE_FILTER_EN` defined: CAPTURE state and `wcnt` are built. Pulses shorter than `PULSE_MIN` samples are rejected and set `glitch_err`.
- `RST_PULSE_FILTER_EN` undefined: CAPTURE and `wcnt` are removed. Any single high sample is accepted. `glitch_err` is tied 0 and `PULSE_MIN` is ignored.

## Test plan
- Defaults, filter on, `rst` held low for 2 cycles then released: all outputs at reset values. Then `rst_pulse` high for 10 cycles → `stage_rst_n`=4'b0000 after E0+10; after the fall, bits 0..3 set at F0+9/17/25/33; `rst_done` pulses once; `busy` falls.
- Filter on, `rst_pulse` high for 3 cycles → `stage_rst_n` stays 4'b1111, `glitch_err`=1 and stays 1 through a later valid pulse.
- Filter off, 1-cycle `rst_pulse` → `stage_rst_n`=4'b0000 after E0+1, then the full release sequence and one `rst_done`.
- Re-trigger with 10-cycle pulse after stage 1 released (`stage_rst_n`=4'b0011) → 4'b0000 on the same edge; no `rst_done` until the restarted sequence completes.
- `rst` asserted mid-RELEASE → immediately `stage_rst_n`=4'b1111, `busy`=0, `rst_done`=0; after `rst` deasserts, state is IDLE.
- `N_STAGES`=1, `STAGE_GAP`=1, filter off → bit 0 released after F0+2, `rst_done` high in the following cycle.

Source files
------------

// File: rtl/rst_pulse_rx_if.sv
// rst_pulse_rx_if: reset-pulse link between pulse generator and receiver.
// Signals: rst_pulse (req), stage_rst_n/busy/rst_done/glitch_err (status).
interface rst_pulse_rx_if #(
    parameter int N_STAGES = 4
);
    logic                rst_pulse;
    logic [N_STAGES-1:0] stage_rst_n;
    logic                busy;
    logic                rst_done;
    logic                glitch_err;

    modport master (
        output rst_pulse,
        input  stage_rst_n,
        input  busy,
        input  rst_done,
        input  glitch_err
    );

    modport slave (
        input  rst_pulse,
        output stage_rst_n,
        output busy,
        output rst_done,
        output glitch_err
    );
endinterface

// File: rtl/rst_pulse_rx.sv
// rst_pulse_rx: qualifies a reset pulse, holds per-domain resets, then
// releases them in ascending order at STAGE_GAP spacing.
// Ports: clk, rst (async active-low), bus (slave): rst_pulse in;
//   stage_rst_n, busy, rst_done, glitch_err out (all registered).
// Option: RST_PULSE_FILTER_EN builds the PULSE_MIN width filter.
module rst_pulse_rx #(
    parameter int PULSE_MIN = 10,
    parameter int N_STAGES  = 4,
    parameter int STAGE_GAP = 8
) (
    input logic           clk,
    input logic           rst,
    rst_pulse_rx_if.slave bus
);
    localparam int GW = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
    localparam int IW = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
    // Illegal parameter sets never leave IDLE.
    localparam bit CFG_OK = (PULSE_MIN >= 1) && (N_STAGES >= 1)
                            && (STAGE_GAP >= 1);
    localparam logic [N_STAGES-1:0] ALL_ONES = {N_STAGES{1'b1}};

`ifdef RST_PULSE_FILTER_EN
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HOLD    = 3'd1,
        RELEASE = 3'd2,
        DONE    = 3'd3,
        CAPTURE = 3'd4
    } state_t;
    localparam int WW = $clog2(PULSE_MIN + 1);
    localparam bit SHORT_MIN = (PULSE_MIN <= 1);
`else
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HOLD    = 3'd1,
        RELEASE = 3'd2,
        DONE    = 3'd3
    } state_t;
`endif

    state_t              state_q;
    state_t              state_d;
    state_t              entry_st;
    logic                p_q;
    logic                trig;
    logic                tick;
    logic                last_rel;
    logic [N_STAGES-1:0] stage_q;
    logic [N_STAGES-1:0] stage_d;
    logic [GW-1:0]       gcnt_q;
    logic [GW-1:0]       gcnt_d;
    logic [IW-1:0]       idx_q;
    logic [IW-1:0]       idx_d;
    logic                done_q;
    logic                done_d;
    logic                busy_q;
    logic                busy_d;

    assign trig     = p_q && CFG_OK;
    assign tick     = (gcnt_q == GW'(STAGE_GAP - 1));
    assign last_rel = tick && (idx_q == IW'(N_STAGES - 1));

    // A pulse (or re-trigger) enters CAPTURE when filtering, else HOLD.
    always_comb begin
        entry_st = HOLD;
`ifdef RST_PULSE_FILTER_EN
        if (!SHORT_MIN) entry_st = CAPTURE;
`endif
    end

`ifdef RST_PULSE_FILTER_EN
    logic [WW-1:0] wcnt_q;
    logic [WW-1:0] wcnt_d;
    logic          glitch_q;
    logic          glitch_d;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (trig) state_d = entry_st;
            end
`ifdef RST_PULSE_FILTER_EN
            CAPTURE: begin
                if (!p_q) begin
                    state_d = (stage_q == ALL_ONES) ? IDLE : RELEASE;
                end else if (int'(wcnt_q) >= PULSE_MIN - 1) begin
                    state_d = HOLD;
                end
            end
`endif
            HOLD: begin
                if (!p_q) state_d = RELEASE;
            end
            RELEASE: begin
                if (trig) state_d = entry_st;
                else if (last_rel) state_d = DONE;
            end
            DONE: begin
                state_d = trig ? entry_st : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stage_d = stage_q;
        gcnt_d  = gcnt_q;
        idx_d   = idx_q;
        unique case (state_q)
`ifdef RST_PULSE_FILTER_EN
            CAPTURE: begin
                gcnt_d = '0;
                idx_d  = '0;
            end
`endif
            HOLD: begin
                gcnt_d = '0;
                idx_d  = '0;
            end
            RELEASE: begin
                if (trig) begin
                    stage_d = '0;
                    gcnt_d  = '0;
                    idx_d   = '0;
                end else if (tick) begin
                    for (int i = 0; i < N_STAGES; i++) begin
                        if (IW'(i) == idx_q) stage_d[i] = 1'b1;
                    end
                    gcnt_d = '0;
                    idx_d  = idx_q + 1'b1;
                end else begin
                    gcnt_d = gcnt_q + 1'b1;
                end
            end
            DONE: begin
                if (trig) stage_d = '0;
            end
            default: ;
        endcase
        if (state_d == HOLD) stage_d = '0;
        done_d = (state_d == DONE);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p_q     <= 1'b0;
            stage_q <= ALL_ONES;
            gcnt_q  <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            p_q     <= bus.rst_pulse;
            stage_q <= stage_d;
            gcnt_q  <= gcnt_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

`ifdef RST_PULSE_FILTER_EN
    // wcnt counts consecutive high samples, saturating at its max.
    always_comb begin
        wcnt_d   = wcnt_q;
        glitch_d = glitch_q;
        if (state_q == CAPTURE) begin
            if (!p_q) begin
                glitch_d = 1'b1;
                wcnt_d   = '0;
            end else if (wcnt_q != {WW{1'b1}}) begin
                wcnt_d = wcnt_q + 1'b1;
            end
        end else if (state_d == CAPTURE) begin
            wcnt_d = WW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wcnt_q   <= '0;
            glitch_q <= 1'b0;
        end else begin
            wcnt_q   <= wcnt_d;
            glitch_q <= glitch_d;
        end
    end

    assign bus.glitch_err = glitch_q;
`else
    assign bus.glitch_err = 1'b0;
`endif

    assign bus.stage_rst_n = stage_q;
    assign bus.busy        = busy_q;
    assign bus.rst_done    = done_q;
endmodule

// File: tb/tb_rst_pulse_rx.sv
// tb_rst_pulse_rx: scoreboard bench; expected output-change events are
// queued by stimulus and matched by per-instance monitors.
module tb_rst_pulse_rx;
`ifdef RST_PULSE_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif
    localparam int PMIN = 10;

    typedef struct {
        int         cyc;
        logic [6:0] v;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   nvec = 0;
    int   nerr = 0;
    bit   g_exp [2];
    ev_t  qa[$];
    ev_t  qb[$];

    rst_pulse_rx_if #(.N_STAGES(4)) ifa ();
    rst_pulse_rx_if #(.N_STAGES(1)) ifb ();

    rst_pulse_rx #(
        .PULSE_MIN(PMIN),
        .N_STAGES (4),
        .STAGE_GAP(8)
    ) dut_a (
        .clk(clk),
        .rst(rst),
        .bus(ifa)
    );

    rst_pulse_rx #(
        .PULSE_MIN(PMIN),
        .N_STAGES (1),
        .STAGE_GAP(1)
    ) dut_b (
        .clk(clk),
        .rst(rst),
        .bus(ifb)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // {glitch_err, busy, rst_done, stage_rst_n padded to 4 with ones}
    function automatic logic [6:0] vec_a();
        return {ifa.glitch_err, ifa.busy, ifa.rst_done, ifa.stage_rst_n};
    endfunction

    function automatic logic [6:0] vec_b();
        return {ifb.glitch_err, ifb.busy, ifb.rst_done, 3'b111,
                ifb.stage_rst_n};
    endfunction

    task automatic push(input int sel, input int c, input logic [6:0] v,
                        input int cut);
        ev_t e;
        e.cyc = c;
        e.v   = v;
        if (cut == 0 || c < cut) begin
            if (sel == 0) qa.push_back(e);
            else qb.push_back(e);
        end
    endtask

    task automatic chk(input string nm, input logic [6:0] got,
                       input logic [6:0] req);
        nvec++;
        if (got !== req) begin
            nerr++;
            $display("FAIL %s got=%b required=%b", nm, got, req);
        end
    endtask

    // Expected events for one pulse of width w whose first high sample
    // is at edge e0, using the documented timing.
    task automatic exp_pulse(input int sel, input int e0, input int w,
                             input bit retrig, input int cut);
        int         n;
        int         gap;
        int         f0;
        logic [3:0] s;
        bit         g;
        n   = (sel != 0) ? 1 : 4;
        gap = (sel != 0) ? 1 : 8;
        s   = 4'b1111 << n;
        g   = g_exp[sel];
        if (retrig) begin
            push(sel, e0 + 1, {g, 1'b1, 1'b0, s}, cut);
        end else if (FILT) begin
            push(sel, e0 + 1, {g, 1'b1, 1'b0, 4'b1111}, cut);
            if (w < PMIN) begin
                g_exp[sel] = 1'b1;
                push(sel, e0 + w + 1, {1'b1, 1'b0, 1'b0, 4'b1111}, cut);
                return;
            end
            push(sel, e0 + PMIN, {g, 1'b1, 1'b0, s}, cut);
        end else begin
            push(sel, e0 + 1, {g, 1'b1, 1'b0, s}, cut);
        end
        f0 = e0 + w;
        for (int i = 0; i < n; i++) begin
            s[i] = 1'b1;
            push(sel, f0 + 1 + (i + 1) * gap,
                 {g, 1'b1, (i == n - 1), s}, cut);
        end
        push(sel, f0 + 2 + n * gap, {g, 1'b0, 1'b0, s}, cut);
    endtask

    task automatic set_p(input int sel, input logic v);
        if (sel == 0) ifa.rst_pulse = v;
        else ifb.rst_pulse = v;
    endtask

    task automatic pulse(input int sel, input int w, input bit retrig,
                         input int cut_rel);
        int e0;
        @(posedge clk);
        #1;
        e0 = cyc + 1;
        exp_pulse(sel, e0, w, retrig, (cut_rel == 0) ? 0 : e0 + cut_rel);
        set_p(sel, 1'b1);
        repeat (w) @(posedge clk);
        #1;
        set_p(sel, 1'b0);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((qa.size() + qb.size()) != 0 && t < 400) begin
            @(posedge clk);
            t++;
        end
        if ((qa.size() + qb.size()) != 0) begin
            nvec++;
            nerr++;
            $display("FAIL drain_timeout pending_a=%0d pending_b=%0d required=0",
                     qa.size(), qb.size());
            qa.delete();
            qb.delete();
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin : mon_a
        logic [6:0] prev;
        logic [6:0] cur;
        ev_t        e;
        @(posedge rst);
        prev = vec_a();
        forever begin
            @(negedge clk);
            cur = vec_a();
            if (cur !== prev) begin
                nvec++;
                if (qa.size() == 0) begin
                    nerr++;
                    $display("FAIL a_unexpected cyc=%0d got=%b required=none",
                             cyc, cur);
                end else begin
                    e = qa.pop_front();
                    if (e.cyc != cyc || e.v !== cur) begin
                        nerr++;
                        $display("FAIL a_event got=%b@%0d required=%b@%0d",
                                 cur, cyc, e.v, e.cyc);
                    end
                end
                prev = cur;
            end
        end
    end

    initial begin : mon_b
        logic [6:0] prev;
        logic [6:0] cur;
        ev_t        e;
        @(posedge rst);
        prev = vec_b();
        forever begin
            @(negedge clk);
            cur = vec_b();
            if (cur !== prev) begin
                nvec++;
                if (qb.size() == 0) begin
                    nerr++;
                    $display("FAIL b_unexpected cyc=%0d got=%b required=none",
                             cyc, cur);
                end else begin
                    e = qb.pop_front();
                    if (e.cyc != cyc || e.v !== cur) begin
                        nerr++;
                        $display("FAIL b_event got=%b@%0d required=%b@%0d",
                                 cur, cyc, e.v, e.cyc);
                    end
                end
                prev = cur;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog cyc=%0d required=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        ifa.rst_pulse = 1'b0;
        ifb.rst_pulse = 1'b0;
        g_exp[0] = 1'b0;
        g_exp[1] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_a", vec_a(), 7'b000_1111);
        rst = 1'b1;
        #1;
        chk("reset_a", vec_a(), 7'b000_1111);
        chk("reset_b", vec_b(), 7'b000_1111);

        // nominal 10-cycle pulse
        pulse(0, 10, 1'b0, 0);
        drain();

        // short pulse: rejected with the filter, accepted without
        pulse(0, 3, 1'b0, 0);
        drain();

        // valid pulse after a possible glitch: glitch_err stays set
        pulse(0, 12, 1'b0, 0);
        drain();

        // re-trigger after stage 1 released (stage_rst_n = 0011)
        pulse(0, 10, 1'b0, 31);
        repeat (19) @(posedge clk);
        #1;
        pulse(0, 10, 1'b1, 0);
        drain();

        // asynchronous reset in the middle of RELEASE
        pulse(0, 10, 1'b0, 22);
        repeat (13) @(posedge clk);
        #1;
        rst = 1'b0;
        push(0, cyc, 7'b000_1111, 0);
        g_exp[0] = 1'b0;
        #1;
        chk("midrst_now", vec_a(), 7'b000_1111);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        drain();
        chk("post_rst_idle", vec_a(), 7'b000_1111);

        // single-sample pulse from IDLE after reset
        pulse(0, 1, 1'b0, 0);
        drain();

        // one stage, gap 1
        pulse(1, 1, 1'b0, 0);
        drain();

        if (qa.size() + qb.size() != 0) begin
            nvec++;
            nerr++;
            $display("FAIL leftover pending=%0d required=0",
                     qa.size() + qb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
